// File: rtl/router_pkg.sv
// Shared router definitions: packet field layout, size encoding and arbiter state encoding.
// Used by the output arbiter and the input-port arbiters.
package router_pkg;

    // Byte index of each packet field; data bytes start at DATA.
    localparam int SRC_ID    = 0;
    localparam int DST_ID    = 1;
    localparam int SIZE      = 2;
    localparam int DATA      = 3;
    localparam int HDR_BYTES = 3;

    localparam int             SIZE_BITS = 3;
    localparam logic [2:0]     SIZE_MASK = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HDR,
        ST_DATA,
        ST_CRC
    } arb_state_t;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester searching upward (cyclic) from ptr+1.
// Returns a one-hot winner and a valid flag.
module rr_picker #(
    parameter int NPORTS = 4,
    parameter int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NPORTS-1:0] win,
    output logic              win_valid
);

    logic [PW-1:0] idx;

    // NOTE: every output of an always_comb block is assigned a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = PW'((int'(ptr) + i) % NPORTS);
            if (!win_valid && req[idx]) begin
                win[idx]  = 1'b1;
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Packet-level round-robin arbiter for one router output link (SRC, DST, SIZE, DATA.., CRC).
// Optional mid-packet idle watchdog enabled by defining ROUTER_ARB_WDOG_EN.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int NPORTS      = 4,
    parameter int UWIDTH      = 8,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        in_valid,
    input  logic [NPORTS*UWIDTH-1:0] in_data,
    input  logic                     out_busy,
    output logic [NPORTS-1:0]        gnt,
    output logic                     out_valid,
    output logic [UWIDTH-1:0]        out_data,
    output logic                     pkt_done,
    output logic                     err
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    if (NPORTS < 2 || NPORTS > 8 || UWIDTH < SIZE_BITS || WDOG_CYCLES < 2) begin : g_param_check
        $error("router_out_arbiter: unsupported parameter combination");
    end

    arb_state_t          state, state_n;
    logic [NPORTS-1:0]   gnt_n, pick;
    logic                pick_valid;
    logic [PW-1:0]       ptr, ptr_n;
    logic [3:0]          cnt, cnt_n;
    logic [SIZE_BITS-1:0] dsz, dsz_n;
    logic                done_n;
    logic                g_valid, g_req, wdog_hit;
    logic [UWIDTH-1:0]   g_data;

    rr_picker #(.NPORTS(NPORTS), .PW(PW)) u_picker (
        .req       (req),
        .ptr       (ptr),
        .win       (pick),
        .win_valid (pick_valid)
    );

    // Only the granted port reaches the link; with no grant everything reads as zero.
    always_comb begin
        g_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt[i]) g_data = in_data[i*UWIDTH +: UWIDTH];
        end
        g_valid = |(in_valid & gnt);
        g_req   = |(req & gnt);
    end

`ifdef ROUTER_ARB_WDOG_EN
    localparam int GW = $clog2(WDOG_CYCLES + 1);
    logic [GW-1:0] gap;

    assign wdog_hit = (state != ST_IDLE) && !g_valid && (gap == GW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap <= '0;
            err <= 1'b0;
        end else begin
            err <= wdog_hit;
            if (state == ST_IDLE || g_valid || wdog_hit) gap <= '0;
            else                                          gap <= gap + 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign err      = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        cnt_n   = cnt;
        dsz_n   = dsz;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (pick_valid && !out_busy) begin
                    gnt_n   = pick;
                    ptr_n   = PW'(onehot_to_idx(8'(pick)));
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (g_valid) begin
                    cnt_n   = 4'(DST_ID);
                    state_n = ST_HDR;
                end else if (!g_req) begin
                    gnt_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (g_valid) begin
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'(SIZE)) begin
                        dsz_n   = g_data[SIZE_BITS-1:0] & SIZE_MASK;
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // cnt holds the absolute byte index, so the last data byte sits at DATA+dsz.
                if (g_valid) begin
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'(DATA) + 4'(dsz)) state_n = ST_CRC;
                end
            end
            ST_CRC: begin
                if (g_valid) begin
                    done_n  = 1'b1;
                    gnt_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
        if (wdog_hit) begin
            gnt_n   = '0;
            state_n = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            ptr       <= PW'(NPORTS - 1);
            cnt       <= '0;
            dsz       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            pkt_done  <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            dsz       <= dsz_n;
            out_valid <= g_valid;
            out_data  <= g_data;
            pkt_done  <= done_n;
        end
    end

endmodule
